minority_detector_seq: RTL and testbench

Sequential vote accumulator that is the counterpart of the combinational majority detectors. It collects a programmable number of single-bit votes serially over a valid/ready handshake and counts the ones. When the last vote is accepted it reports either the minority or the majority value, plus an `equal` flag for a tie. It sits between a serial vote source and any consumer that needs a registered, handshaked decision instead of a parallel vote vector.

---
 rtl/minority_detector_seq_if.sv | 35 +++
 rtl/minority_detector_seq.sv | 131 +++++++++++++
 tb/tb_minority_detector_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/minority_detector_seq_if.sv
// -----------------------------------------------------------------------------
// minority_detector_seq_if
// Groups the vote handshake and the decision outputs of minority_detector_seq.
//   start      : begin a new decision (source -> detector)
//   mode       : 0 = majority, 1 = minority, captured with start
//   vote_valid : source presents a vote
//   vote       : vote bit
//   vote_ready : detector accepts a vote this cycle (detector -> source)
//   busy       : detector is collecting votes
//   done       : one-cycle pulse, decision just became valid
//   out        : decision bit, held until the next accepted start
//   equal      : tie flag, held until the next accepted start
// master = vote source / consumer side, slave = detector side.
// -----------------------------------------------------------------------------
interface minority_detector_seq_if;
    logic start;
    logic mode;
    logic vote_valid;
    logic vote;
    logic vote_ready;
    logic busy;
    logic done;
    logic out;
    logic equal;

    modport master (
        output start, mode, vote_valid, vote,
        input  vote_ready, busy, done, out, equal
    );

    modport slave (
        input  start, mode, vote_valid, vote,
        output vote_ready, busy, done, out, equal
    );
endinterface

// File: rtl/minority_detector_seq.sv
// -----------------------------------------------------------------------------
// minority_detector_seq
// Collects N single-bit votes serially over a valid/ready handshake, counts the
// ones and, on the edge that accepts the N-th vote, registers either the
// majority or the minority value plus a tie flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : minority_detector_seq_if.slave (start/mode/vote handshake in,
//           vote_ready/busy/done/out/equal out, all outputs registered)
// Parameters:
//   N  : votes per decision, 1..255
//   CW : counter / index width, derived from N
// -----------------------------------------------------------------------------
module minority_detector_seq #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    minority_detector_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Decision compares run one bit wider than the counter so 2*ones never
    // overflows, even for N = 255.
    localparam logic [CW:0]   N_EXT    = (CW + 1)'(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t        state_r;
    logic [CW-1:0] ones_r;
    logic [CW-1:0] idx_r;
    logic          mode_r;
    logic          out_r;
    logic          equal_r;
    logic          done_r;
    logic          vote_ready_r;
    logic          busy_r;

    logic          accept_s;
    logic          last_s;
    logic [CW-1:0] ones_next_s;
    logic [CW:0]   twice_s;
    logic          out_next_s;
    logic          eq_next_s;

    // Acceptance and the decision derived from the count including this vote.
    always_comb begin
        accept_s    = bus.vote_valid & vote_ready_r;
        last_s      = (idx_r == LAST_IDX);
        ones_next_s = ones_r + CW'(bus.vote);
        twice_s     = {ones_next_s, 1'b0};
        eq_next_s   = (twice_s == N_EXT);
        // A tie satisfies neither strict compare, so out is 0 on a tie.
        if (mode_r) begin
            out_next_s = (twice_s < N_EXT);
        end else begin
            out_next_s = (twice_s > N_EXT);
        end
    end

    // Control FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ones_r       <= {CW{1'b0}};
            idx_r        <= {CW{1'b0}};
            mode_r       <= 1'b0;
            out_r        <= 1'b0;
            equal_r      <= 1'b0;
            done_r       <= 1'b0;
            vote_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                // IDLE and DONE both launch a new decision on start.
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r      <= COLLECT;
                        ones_r       <= {CW{1'b0}};
                        idx_r        <= {CW{1'b0}};
                        mode_r       <= bus.mode;
                        out_r        <= 1'b0;
                        equal_r      <= 1'b0;
                        vote_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                // start and mode are ignored here; only votes move the state.
                COLLECT: begin
                    if (accept_s) begin
                        ones_r <= ones_next_s;
                        idx_r  <= idx_r + CW'(1);
                        if (last_s) begin
                            state_r      <= DONE;
                            out_r        <= out_next_s;
                            equal_r      <= eq_next_s;
                            done_r       <= 1'b1;
                            vote_ready_r <= 1'b0;
                            busy_r       <= 1'b0;
                        end else begin
                            state_r <= COLLECT;
                        end
                    end else begin
                        state_r <= COLLECT;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    vote_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vote_ready = vote_ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.out        = out_r;
    assign bus.equal      = equal_r;

endmodule

// File: tb/tb_minority_detector_seq.sv
// -----------------------------------------------------------------------------
// tb_minority_detector_seq
// Drives four detector instances (N = 4, 5, 3, 255) from a vector table plus
// hand-written sequences; expected decisions go into a scoreboard queue when a
// decision is launched and are popped when a done pulse is seen.
// -----------------------------------------------------------------------------
module tb_minority_detector_seq;

    typedef struct {
        int         k;
        logic       mode;
        logic [7:0] votes;
        int         nv;
        int         gap_at;
        int         gap_len;
        logic       exp_out;
        logic       exp_eq;
        string      name;
    } vec_t;

    typedef struct {
        int   k;
        logic out;
        logic eq;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic start_a [4];
    logic mode_a  [4];
    logic vv_a    [4];
    logic vote_a  [4];
    logic vr_a    [4];
    logic busy_a  [4];
    logic done_a  [4];
    logic out_a   [4];
    logic eq_a    [4];

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int n_of(input int k);
        case (k)
            0:       return 4;
            1:       return 5;
            2:       return 3;
            default: return 255;
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        minority_detector_seq_if bus_if ();
        assign bus_if.start      = start_a[g];
        assign bus_if.mode       = mode_a[g];
        assign bus_if.vote_valid = vv_a[g];
        assign bus_if.vote       = vote_a[g];
        assign vr_a[g]           = bus_if.vote_ready;
        assign busy_a[g]         = bus_if.busy;
        assign done_a[g]         = bus_if.done;
        assign out_a[g]          = bus_if.out;
        assign eq_a[g]           = bus_if.equal;

        minority_detector_seq #(.N(n_of(g))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus_if)
        );
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_a[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check1("unexpected_done", done_a[k], 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkn("sb_instance", k, e.k);
                    check1("sb_out", out_a[k], e.out);
                    check1("sb_equal", eq_a[k], e.eq);
                end
            end
        end
    end

    task automatic launch(input int k, input logic m);
        start_a[k] = 1'b1;
        mode_a[k]  = m;
        @(negedge clk);
        start_a[k] = 1'b0;
        check1("busy_after_start", busy_a[k], 1'b1);
        check1("ready_after_start", vr_a[k], 1'b1);
        check1("out_cleared", out_a[k], 1'b0);
        check1("equal_cleared", eq_a[k], 1'b0);
    endtask

    task automatic send_votes(input int k, input logic [255:0] v, input int nv,
                              input int gap_at, input int gap_len);
        for (int i = 0; i < nv; i++) begin
            if (i == gap_at) begin
                vv_a[k] = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            vv_a[k]   = 1'b1;
            vote_a[k] = v[i];
            @(negedge clk);
        end
        vv_a[k]   = 1'b0;
        vote_a[k] = 1'b0;
    endtask

    task automatic expect_result(input string name, input int k);
        check1({name, "_done"}, done_a[k], 1'b1);
        check1({name, "_busy_low"}, busy_a[k], 1'b0);
        check1({name, "_ready_low"}, vr_a[k], 1'b0);
    endtask

    task automatic run_vec(input vec_t t);
        exp_q.push_back('{t.k, t.exp_out, t.exp_eq});
        launch(t.k, t.mode);
        mode_a[t.k] = ~t.mode;
        send_votes(t.k, 256'(t.votes), t.nv, t.gap_at, t.gap_len);
        expect_result(t.name, t.k);
        repeat (10) @(negedge clk);
        check1({t.name, "_out_held"}, out_a[t.k], t.exp_out);
        check1({t.name, "_equal_held"}, eq_a[t.k], t.exp_eq);
        check1({t.name, "_done_once"}, done_a[t.k], 1'b0);
    endtask

    vec_t tv [10];

    initial begin
        logic [255:0] v;
        for (int k = 0; k < 4; k++) begin
            start_a[k] = 1'b0;
            mode_a[k]  = 1'b0;
            vv_a[k]    = 1'b0;
            vote_a[k]  = 1'b0;
        end

        // votes: bit i is the i-th vote sent
        tv[0] = '{0, 1'b0, 8'b0000_0111, 4, -1, 0, 1'b1, 1'b0, "maj4_1110"};
        tv[1] = '{0, 1'b0, 8'b0000_0101, 4, -1, 0, 1'b0, 1'b1, "maj4_tie"};
        tv[2] = '{0, 1'b1, 8'b0000_0101, 4, -1, 0, 1'b0, 1'b1, "min4_tie"};
        tv[3] = '{1, 1'b1, 8'b0000_1011, 5,  2, 3, 1'b0, 1'b0, "min5_stall"};
        tv[4] = '{1, 1'b0, 8'b0000_1011, 5,  2, 3, 1'b1, 1'b0, "maj5_stall"};
        tv[5] = '{0, 1'b1, 8'b0000_1000, 4, -1, 0, 1'b1, 1'b0, "min4_0001"};
        tv[6] = '{0, 1'b0, 8'b0000_0000, 4, -1, 0, 1'b0, 1'b0, "maj4_zeros"};
        tv[7] = '{2, 1'b1, 8'b0000_0100, 3, -1, 0, 1'b1, 1'b0, "min3_001"};
        tv[8] = '{0, 1'b1, 8'b0000_1111, 4, -1, 0, 1'b0, 1'b0, "min4_ones"};
        tv[9] = '{1, 1'b1, 8'b0000_0001, 5, -1, 0, 1'b1, 1'b0, "min5_10000"};

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check1("rst_ready", vr_a[k], 1'b0);
            check1("rst_busy", busy_a[k], 1'b0);
            check1("rst_done", done_a[k], 1'b0);
            check1("rst_out", out_a[k], 1'b0);
            check1("rst_equal", eq_a[k], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(tv[i]);
        end

        // Reset in the middle of a collection discards the partial count.
        run_vec(tv[0]);
        launch(0, 1'b0);
        v = '1;
        send_votes(0, v, 2, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("midrst_ready", vr_a[0], 1'b0);
        check1("midrst_busy", busy_a[0], 1'b0);
        check1("midrst_done", done_a[0], 1'b0);
        check1("midrst_out", out_a[0], 1'b0);
        check1("midrst_equal", eq_a[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec('{0, 1'b0, 8'b0000_0000, 4, -1, 0, 1'b0, 1'b0, "post_reset"});

        // start and mode toggled while collecting must not disturb the count.
        exp_q.push_back('{2, 1'b0, 1'b0});
        launch(2, 1'b0);
        vv_a[2] = 1'b1; vote_a[2] = 1'b0;
        @(negedge clk);
        start_a[2] = 1'b1; mode_a[2] = 1'b1;
        @(negedge clk);
        start_a[2] = 1'b0;
        check1("midstart_busy", busy_a[2], 1'b1);
        vote_a[2] = 1'b1;
        @(negedge clk);
        vv_a[2] = 1'b0; vote_a[2] = 1'b0;
        expect_result("midstart", 2);
        repeat (3) @(negedge clk);

        // Back-to-back decisions with N = 255, start held in the DONE cycle.
        exp_q.push_back('{3, 1'b1, 1'b0});
        exp_q.push_back('{3, 1'b0, 1'b0});
        launch(3, 1'b0);
        v = '1;
        send_votes(3, v, 255, -1, 0);
        expect_result("b2b_first", 3);
        check1("b2b_first_out", out_a[3], 1'b1);
        start_a[3] = 1'b1;
        mode_a[3]  = 1'b0;
        @(negedge clk);
        start_a[3] = 1'b0;
        check1("b2b_restart_busy", busy_a[3], 1'b1);
        check1("b2b_restart_out_clr", out_a[3], 1'b0);
        check1("b2b_restart_done_low", done_a[3], 1'b0);
        v = '0;
        for (int i = 0; i < 127; i++) v[i] = 1'b1;
        send_votes(3, v, 255, -1, 0);
        expect_result("b2b_second", 3);
        check1("b2b_second_out", out_a[3], 1'b0);
        check1("b2b_second_equal", eq_a[3], 1'b0);
        repeat (3) @(negedge clk);

        checkn("sb_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
